// File: rtl/pet_uart_tx.sv
// Buffered 8N1 UART transmitter: byte FIFO feeding an LSB-first serializer.
// Define PET_UART_TX_PARITY_EN to insert an even-parity bit before the stop bit.
module pet_uart_tx #(
  parameter int CLK_DIVIDER = 5208,
  parameter int FIFO_AW     = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] write_data,
  input  logic       write_strobe,
  output logic       write_rdy,
  output logic       serial_out,
  output logic       busy,
  output logic       overflow
);

  localparam int               DEPTH      = 1 << FIFO_AW;
  localparam logic [FIFO_AW:0] FULL_COUNT = (FIFO_AW + 1)'(DEPTH);
  localparam logic [FIFO_AW:0] ZERO_COUNT = (FIFO_AW + 1)'(0);
  localparam logic [FIFO_AW:0] ONE_COUNT  = (FIFO_AW + 1)'(1);
  localparam logic [FIFO_AW-1:0] ONE_PTR  = FIFO_AW'(1);
  localparam logic [15:0]      TIMER_LOAD = 16'(CLK_DIVIDER - 1);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
`ifdef PET_UART_TX_PARITY_EN
    ST_PARITY = 3'd4,
`endif
    ST_STOP   = 3'd3
  } state_t;

`ifdef PET_UART_TX_PARITY_EN
  function automatic logic even_parity(input logic [7:0] b);
    return ^b;
  endfunction
`endif

  state_t             state_r;
  state_t             state_nxt_s;
  logic [7:0]         mem_r [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr_r;
  logic [FIFO_AW-1:0] rd_ptr_r;
  logic [FIFO_AW:0]   count_r;
  logic [15:0]        timer_r;
  logic [7:0]         shift_r;
  logic [2:0]         bit_idx_r;
  logic               serial_r;
  logic               overflow_r;
`ifdef PET_UART_TX_PARITY_EN
  logic               parity_r;
`endif

  logic       fifo_empty_s;
  logic       push_s;
  logic       pop_s;
  logic       tick_s;
  logic       load_s;
  logic       shift_s;
  logic       serial_nxt_s;
  logic [7:0] head_s;

  assign fifo_empty_s = (count_r == ZERO_COUNT);
  assign write_rdy    = (count_r != FULL_COUNT);
  assign push_s       = write_strobe && write_rdy;
  assign tick_s       = (timer_r == 16'd0);
  assign head_s       = mem_r[rd_ptr_r];
  assign serial_out   = serial_r;
  assign overflow     = overflow_r;
  assign busy         = (state_r != ST_IDLE) || !fifo_empty_s;

  // FSM state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state decode; each non-idle state advances only on timer expiry
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (!fifo_empty_s) state_nxt_s = ST_START;
        else               state_nxt_s = ST_IDLE;
      end
      ST_START: begin
        if (tick_s) state_nxt_s = ST_DATA;
        else        state_nxt_s = ST_START;
      end
      ST_DATA: begin
        if (tick_s && (bit_idx_r == 3'd7)) begin
`ifdef PET_UART_TX_PARITY_EN
          state_nxt_s = ST_PARITY;
`else
          state_nxt_s = ST_STOP;
`endif
        end else begin
          state_nxt_s = ST_DATA;
        end
      end
`ifdef PET_UART_TX_PARITY_EN
      ST_PARITY: begin
        if (tick_s) state_nxt_s = ST_STOP;
        else        state_nxt_s = ST_PARITY;
      end
`endif
      ST_STOP: begin
        if (tick_s) state_nxt_s = fifo_empty_s ? ST_IDLE : ST_START;
        else        state_nxt_s = ST_STOP;
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Output decode: pops, timer reloads and the next line level
  always_comb begin
    pop_s        = 1'b0;
    load_s       = 1'b0;
    shift_s      = 1'b0;
    serial_nxt_s = serial_r;
    case (state_r)
      ST_IDLE: begin
        if (!fifo_empty_s) begin
          pop_s        = 1'b1;
          load_s       = 1'b1;
          serial_nxt_s = 1'b0;
        end else begin
          serial_nxt_s = 1'b1;
        end
      end
      ST_START: begin
        if (tick_s) begin
          load_s       = 1'b1;
          shift_s      = 1'b1;
          serial_nxt_s = shift_r[0];
        end else begin
          serial_nxt_s = serial_r;
        end
      end
      ST_DATA: begin
        if (tick_s && (bit_idx_r == 3'd7)) begin
          load_s = 1'b1;
`ifdef PET_UART_TX_PARITY_EN
          serial_nxt_s = parity_r;
`else
          serial_nxt_s = 1'b1;
`endif
        end else if (tick_s) begin
          load_s       = 1'b1;
          shift_s      = 1'b1;
          serial_nxt_s = shift_r[0];
        end else begin
          serial_nxt_s = serial_r;
        end
      end
`ifdef PET_UART_TX_PARITY_EN
      ST_PARITY: begin
        if (tick_s) begin
          load_s       = 1'b1;
          serial_nxt_s = 1'b1;
        end else begin
          serial_nxt_s = serial_r;
        end
      end
`endif
      ST_STOP: begin
        if (tick_s && !fifo_empty_s) begin
          pop_s        = 1'b1;
          load_s       = 1'b1;
          serial_nxt_s = 1'b0;
        end else if (tick_s) begin
          serial_nxt_s = 1'b1;
        end else begin
          serial_nxt_s = serial_r;
        end
      end
      default: serial_nxt_s = 1'b1;
    endcase
  end

  // FIFO storage; contents are meaningless until written, so no reset
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= write_data;
    end else begin
      mem_r[wr_ptr_r] <= mem_r[wr_ptr_r];
    end
  end

  // FIFO pointers, occupancy and sticky overflow
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_r   <= {FIFO_AW{1'b0}};
      rd_ptr_r   <= {FIFO_AW{1'b0}};
      count_r    <= ZERO_COUNT;
      overflow_r <= 1'b0;
    end else begin
      if (push_s) wr_ptr_r <= wr_ptr_r + ONE_PTR;
      if (pop_s)  rd_ptr_r <= rd_ptr_r + ONE_PTR;
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + ONE_COUNT;
        2'b01:   count_r <= count_r - ONE_COUNT;
        default: count_r <= count_r;
      endcase
      if (write_strobe && !write_rdy) overflow_r <= 1'b1;
    end
  end

  // Serializer datapath: bit timer, shift register, bit index, line register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      timer_r   <= 16'd0;
      shift_r   <= 8'd0;
      bit_idx_r <= 3'd0;
      serial_r  <= 1'b1;
`ifdef PET_UART_TX_PARITY_EN
      parity_r  <= 1'b0;
`endif
    end else begin
      serial_r <= serial_nxt_s;
      if (load_s) begin
        timer_r <= TIMER_LOAD;
      end else if ((state_r != ST_IDLE) && !tick_s) begin
        timer_r <= timer_r - 16'd1;
      end
      if (pop_s) begin
        shift_r <= head_s;
`ifdef PET_UART_TX_PARITY_EN
        parity_r <= even_parity(head_s);
`endif
      end else if (shift_s) begin
        shift_r <= {1'b0, shift_r[7:1]};
      end
      if (shift_s && (state_r == ST_START)) begin
        bit_idx_r <= 3'd0;
      end else if (shift_s) begin
        bit_idx_r <= bit_idx_r + 3'd1;
      end
    end
  end

endmodule

// File: tb/tb_pet_uart_tx.sv
// Self-checking bench for pet_uart_tx (CLK_DIVIDER=4, FIFO_AW=2) against a
// frame-level reference model: a frame is SLOTS levels of DIV clocks each.
module tb_pet_uart_tx;
  localparam int DIV   = 4;
  localparam int AW    = 2;
  localparam int DEPTH = 4;
`ifdef PET_UART_TX_PARITY_EN
  localparam int SLOTS = 11;
`else
  localparam int SLOTS = 10;
`endif
  localparam int F = SLOTS * DIV;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [7:0] write_data = 8'h00;
  logic       write_strobe = 1'b0;
  logic       write_rdy, serial_out, busy, overflow;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  pet_uart_tx #(.CLK_DIVIDER(DIV), .FIFO_AW(AW)) dut (
    .clk(clk), .reset_n(reset_n), .write_data(write_data),
    .write_strobe(write_strobe), .write_rdy(write_rdy),
    .serial_out(serial_out), .busy(busy), .overflow(overflow));

  // Reference model: queued bytes, clocks left in current frame, sticky overflow
  logic [7:0] m_q[$];
  int         m_rem = 0;
  logic [7:0] m_cur = 8'h00;
  logic       m_ovf = 1'b0;
  int         frames = 0;
  int         bad_line, bad_busy, bad_rdy, bad_ovf;

  function automatic logic frame_level(input logic [7:0] b, input int slot);
    if (slot == 0) return 1'b0;
    if (slot <= 8) return b[slot-1];
    if (slot == 9 && SLOTS == 11) return ^b;
    return 1'b1;
  endfunction

  task automatic mdl_reset();
    m_q.delete();
    m_rem = 0;
    m_ovf = 1'b0;
  endtask

  task automatic clear_counts();
    bad_line = 0; bad_busy = 0; bad_rdy = 0; bad_ovf = 0;
  endtask

  // One clock: drive inputs, advance the model, sample DUT 1 time unit after the edge
  task automatic step(input logic s, input logic [7:0] d);
    logic rdy, pop, e_line, e_busy;
    @(negedge clk);
    write_strobe = s;
    write_data   = d;
    @(posedge clk);
    rdy = (m_q.size() != DEPTH);
    pop = (m_q.size() != 0) && (m_rem <= 1);
    if (s && !rdy) m_ovf = 1'b1;
    if (s && rdy) m_q.push_back(d);
    if (pop) begin
      m_cur = m_q.pop_front();
      m_rem = F;
      frames++;
    end else if (m_rem > 0) begin
      m_rem--;
    end
    #1;
    e_line = (m_rem > 0) ? frame_level(m_cur, (F - m_rem) / DIV) : 1'b1;
    e_busy = (m_rem > 0) || (m_q.size() != 0);
    if (serial_out !== e_line) bad_line++;
    if (busy !== e_busy) bad_busy++;
    if (write_rdy !== (m_q.size() != DEPTH)) bad_rdy++;
    if (overflow !== m_ovf) bad_ovf++;
  endtask

  task automatic hard_reset();
    @(negedge clk);
    reset_n = 1'b0;
    write_strobe = 1'b0;
    mdl_reset();
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    #12;
    checks++; if (serial_out !== 1'b1) begin errors++; $display("FAIL reset_line: got %b expected 1", serial_out); end
    checks++; if (write_rdy !== 1'b1) begin errors++; $display("FAIL reset_rdy: got %b expected 1", write_rdy); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b expected 0", overflow); end
    mdl_reset();
    @(negedge clk);
    reset_n = 1'b1;
    clear_counts();
    for (int i = 0; i < 6; i++) step(1'b0, 8'h00);
    checks++; if (bad_line + bad_busy + bad_rdy + bad_ovf !== 0) begin errors++;
      $display("FAIL reset_idle: got %0d mismatches expected 0", bad_line + bad_busy + bad_rdy + bad_ovf); end
  endtask

  task automatic test_single(input logic [7:0] b);
    logic line[1:48];
    logic bsy[1:48];
    int   bad, f0;
    clear_counts();
    f0 = frames;
    step(1'b1, b);
    checks++; if (serial_out !== 1'b1) begin errors++; $display("FAIL single_e0_line %h: got %b expected 1", b, serial_out); end
    for (int k = 1; k <= F + 6; k++) begin
      step(1'b0, 8'h00);
      line[k] = serial_out;
      bsy[k]  = busy;
    end
    bad = 0;
    for (int k = 1; k <= F + 6; k++) begin
      if (line[k] !== ((k <= F) ? frame_level(b, (k - 1) / DIV) : 1'b1)) bad++;
    end
    checks++; if (bad !== 0) begin errors++; $display("FAIL single_wave %h: got %0d bad clocks expected 0", b, bad); end
    checks++; if (bsy[F] !== 1'b1) begin errors++; $display("FAIL single_busy_last %h: got %b expected 1", b, bsy[F]); end
    checks++; if (bsy[F+1] !== 1'b0) begin errors++; $display("FAIL single_busy_drop %h: got %b expected 0", b, bsy[F+1]); end
    checks++; if (frames - f0 !== 1) begin errors++; $display("FAIL single_frames: got %0d expected 1", frames - f0); end
    checks++; if (bad_line + bad_busy + bad_rdy + bad_ovf !== 0) begin errors++;
      $display("FAIL single_model %h: got %0d mismatches expected 0", b, bad_line + bad_busy + bad_rdy + bad_ovf); end
  endtask

  task automatic test_back_to_back();
    logic line[1:100];
    int   bad;
    clear_counts();
    step(1'b1, 8'h00);
    step(1'b1, 8'hFF);
    line[1] = serial_out;
    for (int k = 2; k <= 2 * F + 6; k++) begin
      step(1'b0, 8'h00);
      line[k] = serial_out;
    end
    bad = 0;
    for (int k = 1; k <= 2 * F + 6; k++) begin
      if (line[k] !== ((k <= F) ? frame_level(8'h00, (k - 1) / DIV) :
                       (k <= 2 * F) ? frame_level(8'hFF, (k - 1 - F) / DIV) : 1'b1)) bad++;
    end
    checks++; if (bad !== 0) begin errors++; $display("FAIL b2b_wave: got %0d bad clocks expected 0", bad); end
    checks++; if (line[F-4] !== 1'b0) begin errors++; $display("FAIL b2b_before_stop: got %b expected 0", line[F-4]); end
    checks++; if (line[F+1] !== 1'b0) begin errors++; $display("FAIL b2b_no_gap: got %b expected 0", line[F+1]); end
    checks++; if (bad_line + bad_busy + bad_rdy + bad_ovf !== 0) begin errors++;
      $display("FAIL b2b_model: got %0d mismatches expected 0", bad_line + bad_busy + bad_rdy + bad_ovf); end
  endtask

  task automatic test_overflow();
    logic rdy[6];
    logic ovf[6];
    int   f0;
    hard_reset();
    clear_counts();
    f0 = frames;
    for (int i = 0; i < 6; i++) begin
      step(1'b1, 8'($urandom));
      rdy[i] = write_rdy;
      ovf[i] = overflow;
    end
    checks++; if (rdy[3] !== 1'b1) begin errors++; $display("FAIL ovf_rdy4: got %b expected 1", rdy[3]); end
    checks++; if (rdy[4] !== 1'b0) begin errors++; $display("FAIL ovf_rdy5: got %b expected 0", rdy[4]); end
    checks++; if (ovf[4] !== 1'b0) begin errors++; $display("FAIL ovf_early: got %b expected 0", ovf[4]); end
    checks++; if (ovf[5] !== 1'b1) begin errors++; $display("FAIL ovf_set: got %b expected 1", ovf[5]); end
    for (int k = 0; k < 5 * F + 10; k++) step(1'b0, 8'h00);
    checks++; if (frames - f0 !== 5) begin errors++; $display("FAIL ovf_frames: got %0d expected 5", frames - f0); end
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky: got %b expected 1", overflow); end
    checks++; if (bad_line + bad_busy + bad_rdy + bad_ovf !== 0) begin errors++;
      $display("FAIL ovf_model: got %0d mismatches expected 0", bad_line + bad_busy + bad_rdy + bad_ovf); end
  endtask

  task automatic test_full_pop();
    int   f0;
    logic rdy_before;
    hard_reset();
    clear_counts();
    f0 = frames;
    for (int i = 0; i < 5; i++) step(1'b1, 8'($urandom));
    for (int i = 0; i < F - 4; i++) step(1'b0, 8'h00);
    rdy_before = write_rdy;
    step(1'b1, 8'h5A);
    checks++; if (rdy_before !== 1'b0) begin errors++; $display("FAIL fullpop_full: got %b expected 0", rdy_before); end
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL fullpop_ovf: got %b expected 1", overflow); end
    checks++; if (write_rdy !== 1'b1) begin errors++; $display("FAIL fullpop_rdy: got %b expected 1", write_rdy); end
    for (int k = 0; k < 4 * F + 10; k++) step(1'b0, 8'h00);
    checks++; if (frames - f0 !== 5) begin errors++; $display("FAIL fullpop_frames: got %0d expected 5", frames - f0); end
    checks++; if (bad_line + bad_busy + bad_rdy + bad_ovf !== 0) begin errors++;
      $display("FAIL fullpop_model: got %0d mismatches expected 0", bad_line + bad_busy + bad_rdy + bad_ovf); end
  endtask

  task automatic test_reset_midframe();
    int bad, f0;
    hard_reset();
    clear_counts();
    step(1'b1, 8'h3C);
    step(1'b1, 8'h11);
    step(1'b1, 8'h22);
    for (int i = 0; i < 16; i++) step(1'b0, 8'h00);
    checks++; if (serial_out !== 1'b1) begin errors++; $display("FAIL mid_bit3: got %b expected 1", serial_out); end
    @(posedge clk);
    #2;
    reset_n = 1'b0;
    mdl_reset();
    #1;
    checks++; if (serial_out !== 1'b1) begin errors++; $display("FAIL mid_line: got %b expected 1", serial_out); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_busy: got %b expected 0", busy); end
    checks++; if (write_rdy !== 1'b1) begin errors++; $display("FAIL mid_rdy: got %b expected 1", write_rdy); end
    @(negedge clk);
    reset_n = 1'b1;
    clear_counts();
    f0 = frames;
    bad = 0;
    for (int k = 0; k < 3 * F; k++) begin
      step(1'b0, 8'h00);
      if (serial_out !== 1'b1 || busy !== 1'b0) bad++;
    end
    checks++; if (bad !== 0) begin errors++; $display("FAIL mid_after: got %0d active clocks expected 0", bad); end
    step(1'b1, 8'($urandom));
    for (int k = 0; k < F + 4; k++) step(1'b0, 8'h00);
    checks++; if (frames - f0 !== 1 || bad_line + bad_busy + bad_rdy + bad_ovf !== 0) begin errors++;
      $display("FAIL mid_restart: got %0d frames %0d mismatches expected 1 frame 0 mismatches",
               frames - f0, bad_line + bad_busy + bad_rdy + bad_ovf); end
  endtask

  task automatic test_parity();
    logic [7:0] b;
    logic       slot9, bsy_last, bsy_drop;
    for (int n = 0; n < 2; n++) begin
      b = (n == 0) ? 8'h07 : 8'h03;
      clear_counts();
      step(1'b1, b);
      for (int k = 1; k <= F + 2; k++) begin
        step(1'b0, 8'h00);
        if (k == 9 * DIV + 2) slot9 = serial_out;
        if (k == F) bsy_last = busy;
        if (k == F + 1) bsy_drop = busy;
      end
      checks++; if (slot9 !== frame_level(b, 9)) begin errors++;
        $display("FAIL parity_slot9 %h: got %b expected %b", b, slot9, frame_level(b, 9)); end
      checks++; if (bsy_last !== 1'b1 || bsy_drop !== 1'b0) begin errors++;
        $display("FAIL parity_len %h: got busy %b/%b expected 1/0", b, bsy_last, bsy_drop); end
    end
  endtask

  task automatic test_random();
    int f0;
    hard_reset();
    clear_counts();
    f0 = frames;
    for (int k = 0; k < 1500; k++) begin
      if ((k / 200) % 2 == 0) step($urandom_range(0, 3) == 0, 8'($urandom));
      else                    step($urandom_range(0, 63) == 0, 8'($urandom));
    end
    for (int k = 0; k < 6 * F; k++) step(1'b0, 8'h00);
    checks++; if (bad_line + bad_busy + bad_rdy + bad_ovf !== 0) begin errors++;
      $display("FAIL random_model: got line %0d busy %0d rdy %0d ovf %0d mismatches expected 0",
               bad_line, bad_busy, bad_rdy, bad_ovf); end
    checks++; if (frames - f0 < 10) begin errors++; $display("FAIL random_activity: got %0d frames expected >= 10", frames - f0); end
  endtask

  initial begin
    test_reset();
    test_single(8'hA5);
    test_single(8'($urandom));
    test_back_to_back();
    test_overflow();
    test_full_pop();
    test_reset_midframe();
    test_parity();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pet_uart_tx.md
# pet_uart_tx

Buffered 8N1 UART transmitter that serves as the send side of the board's serial link, opposite the existing receive path that turns host characters into PET keystrokes. Bytes from PET-side logic (screen-echo, diagnostics, cassette-to-serial bridges) are pushed through a `write_data`/`write_strobe`/`write_rdy` handshake into a small FIFO. Each byte is then serialized LSB-first onto `serial_out`, which drives `UART_RXD_OUT`.

## Interface
Parameters:
- `CLK_DIVIDER`, default 5208: clocks per bit (50 MHz / 9600 baud); legal range 2..65535.
- `FIFO_AW`, default 4: FIFO address width; depth = 2^FIFO_AW (16).

Ports:
- `clk`  in  1  system clock, 50 MHz.
- `reset_n`  in  1  asynchronous, active-low reset. One clock; reset is asynchronous and active-low.
- `write_data`  in  8  byte to enqueue.
- `write_strobe`  in  1  one-cycle enqueue request.
- `write_rdy`  out  1  high when the FIFO is not full.
- `serial_out`  out  1  UART line, idle high, registered.
- `busy`  out  1  high while a frame is in progress or the FIFO is non-empty.
- `overflow`  out  1  sticky flag: a strobe arrived while `write_rdy` was low.

## Operation
Reset values (async, `reset_n` low):
- `serial_out`=1, `write_rdy`=1, `busy`=0, `overflow`=0.
- FIFO empty, FSM in IDLE, bit timer 0.

FIFO:
- Synchronous write on `write_strobe && write_rdy`.
- Count width is FIFO_AW+1; pointers wrap modulo 2^FIFO_AW.
- `write_rdy` = (count != depth), decoded from registered count.
- Strobe while full: data dropped, `overflow` set to 1, held until reset.
- Write and pop in the same cycle: count unchanged. This is legal only when not full, because `write_rdy` gates the write even if a pop happens that cycle.

FSM states: IDLE, START, DATA, PARITY (only with macro), STOP.
- IDLE: if FIFO non-empty, pop the head into shift register, drive `serial_out`=0, load timer with CLK_DIVIDER-1, go to START.
- START: when timer==0, output bit0, reload timer, bit index=0, go to DATA.
- DATA: when timer==0, shift. After bit7 completes, go to PARITY (macro) or STOP, driving 1 (STOP) or the parity bit.
- PARITY: when timer==0, drive 1, go to STOP.
- STOP: when timer==0:
  - if FIFO non-empty, pop and go directly to START with `serial_out`=0 (no idle gap);
  - otherwise drive 1 and go to IDLE.
- Timer decrements every clock while not IDLE; each line level lasts exactly CLK_DIVIDER clocks.
- `busy` = (state != IDLE) || (count != 0).

## Timing
- Strobe sampled at edge E0 into an empty FIFO with FSM in IDLE: the FIFO becomes non-empty after E0, and `serial_out` falls after edge E0+1.
- Start bit spans CLK_DIVIDER clocks, followed by 8 data bits LSB-first, then the stop bit.
- Frame = 10×CLK_DIVIDER clocks (11× with parity).
- Back-to-back frames: the next start bit begins on the clock immediately after the stop bit's last clock.
- `write_rdy` reflects a pop one clock after the pop edge.
- `reset_n` asserted mid-frame: line forced high immediately, frame aborted, FIFO contents discarded. After deassertion, the first strobe behaves as from power-up.

## Configuration
- `PET_UART_TX_PARITY_EN` defined: an even-parity bit (XOR of the 8 data bits) is inserted between bit7 and stop. Frame = 11×CLK_DIVIDER.
- Not defined: the PARITY state and parity logic are absent, producing plain 8N1 with 10×CLK_DIVIDER frames.

## Test plan
All scenarios use CLK_DIVIDER=4 and FIFO_AW=2.
1. Reset then strobe 8'hA5 once:
   - `serial_out` low 4 clocks starting one clock after the strobe edge;
   - then 1,0,1,0,0,1,0,1, 4 clocks each;
   - then high; `busy` drops 40 clocks after the start bit began.
2. Strobe 8'h00 and 8'hFF on consecutive cycles:
   - two frames with no idle clocks between the stop bit of frame 1 and the start bit of frame 2;
   - stop bit exactly 4 clocks.
3. Strobe 6 bytes back-to-back while idle:
   - first pops immediately;
   - `write_rdy` falls after the 5th accepted write;
   - 6th strobe dropped and `overflow`=1;
   - exactly 5 frames emitted.
4. Assert `reset_n` low during bit3 of 8'h3C with 2 bytes queued:
   - `serial_out`=1 asynchronously, `busy`=0, `write_rdy`=1;
   - no further frames after release.
5. With `PET_UART_TX_PARITY_EN`, send 8'h07:
   - parity bit=1 in slot 9, frame 44 clocks.
   - Send 8'h03: parity bit=0.
6. Strobe during the last clock of a stop bit while the FIFO is full:
   - strobe rejected (`overflow`=1) even though a pop occurs the same cycle;
   - count ends at depth−1.
